// File: rtl/fwrisc_regfile_p.sv
// -----------------------------------------------------------------------------
// fwrisc_regfile_p
//
// Parametrised register file for the fwrisc core. It sits between decode
// (read addresses) and writeback (single write port).
//
// Storage is not reset directly. Instead, a clear sequencer walks every entry
// and writes zero to it. The sweep runs after reset and again whenever
// clr_req is pulsed. While the sweep runs, ready is low, writes are dropped
// and every read port returns zero.
//
// Parameters:
//   DATA_WIDTH - width of each entry
//   ADDR_WIDTH - address width; depth = 2**ADDR_WIDTH
//   N_READ     - number of asynchronous read ports (1..4)
//   ZERO_REG   - 1: entry 0 always reads zero and ignores writes
//   BYPASS     - 1: a read of the address being written this cycle
//                returns rd_wdata
//
// Ports:
//   clock    - single clock; all state updates on the rising edge
//   reset    - asynchronous, active-low reset
//   raddr    - read addresses; port i at [i*ADDR_WIDTH +: ADDR_WIDTH]
//   rdata    - read data;     port i at [i*DATA_WIDTH +: DATA_WIDTH]
//   rd_waddr - write address
//   rd_wdata - write data
//   rd_wen   - write enable (honoured only while ready)
//   clr_req  - pulse: start (or restart) a clear sweep
//   ready    - 1 when the file is in RUN state
// -----------------------------------------------------------------------------
module fwrisc_regfile_p #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 6,
    parameter int N_READ     = 2,
    parameter int ZERO_REG   = 1,
    parameter int BYPASS     = 1
) (
    input  logic                           clock,
    input  logic                           reset,
    input  logic [N_READ*ADDR_WIDTH-1:0]   raddr,
    output logic [N_READ*DATA_WIDTH-1:0]   rdata,
    input  logic [ADDR_WIDTH-1:0]          rd_waddr,
    input  logic [DATA_WIDTH-1:0]          rd_wdata,
    input  logic                           rd_wen,
    input  logic                           clr_req,
    output logic                           ready
);

    localparam int DEPTH = 1 << ADDR_WIDTH;
    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = {ADDR_WIDTH{1'b1}};
    localparam logic [ADDR_WIDTH-1:0] CNT_ONE   = ADDR_WIDTH'(1'b1);

    typedef enum logic [0:0] {
        ST_CLEAR = 1'b0,
        ST_RUN   = 1'b1
    } state_t;

    state_t                  state_r;
    state_t                  state_s;
    logic [ADDR_WIDTH-1:0]   cnt_r;
    logic [ADDR_WIDTH-1:0]   cnt_s;
    logic                    ready_r;

    logic [DATA_WIDTH-1:0]   mem_r [0:DEPTH-1];

    logic                    zero_hit_s;
    logic                    mem_we_s;
    logic [ADDR_WIDTH-1:0]   mem_waddr_s;
    logic [DATA_WIDTH-1:0]   mem_wdata_s;

    // Next-state logic for the clear sequencer and its sweep counter.
    always_comb begin
        state_s = state_r;
        cnt_s   = cnt_r;
        case (state_r)
            ST_CLEAR: begin
                if (clr_req) begin
                    // A new request restarts the sweep from entry 0.
                    cnt_s = '0;
                end else if (cnt_r == LAST_ADDR) begin
                    // The last entry is written on this edge. The counter
                    // never wraps; this compare is what ends the sweep.
                    state_s = ST_RUN;
                    cnt_s   = '0;
                end else begin
                    cnt_s = cnt_r + CNT_ONE;
                end
            end
            ST_RUN: begin
                if (clr_req) begin
                    state_s = ST_CLEAR;
                    cnt_s   = '0;
                end else begin
                    cnt_s = '0;
                end
            end
            default: begin
                state_s = ST_CLEAR;
                cnt_s   = '0;
            end
        endcase
    end

    // Sequencer state, sweep counter and registered ready flag.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_r <= ST_CLEAR;
            cnt_r   <= '0;
            ready_r <= 1'b0;
        end else begin
            state_r <= state_s;
            cnt_r   <= cnt_s;
            ready_r <= (state_s == ST_RUN);
        end
    end

    assign ready = ready_r;

    // Entry 0 is hard-wired only when ZERO_REG is set.
    assign zero_hit_s = (ZERO_REG != 0) && (rd_waddr == '0);

    // Select the single storage write: the sweep has priority over the port.
    always_comb begin
        mem_we_s    = 1'b0;
        mem_waddr_s = rd_waddr;
        mem_wdata_s = rd_wdata;
        if (state_r == ST_CLEAR) begin
            mem_we_s    = 1'b1;
            mem_waddr_s = cnt_r;
            mem_wdata_s = '0;
        end else if (rd_wen && !zero_hit_s) begin
            mem_we_s    = 1'b1;
            mem_waddr_s = rd_waddr;
            mem_wdata_s = rd_wdata;
        end else begin
            mem_we_s    = 1'b0;
        end
    end

    // Storage array. It has no reset; the clear sweep initialises it.
    always_ff @(posedge clock) begin
        if (mem_we_s) begin
            mem_r[mem_waddr_s] <= mem_wdata_s;
        end
    end

    // Independent combinational read ports.
    for (genvar gi = 0; gi < N_READ; gi++) begin : g_rd
        logic [ADDR_WIDTH-1:0] ra_s;
        logic [DATA_WIDTH-1:0] rd_s;

        assign ra_s = raddr[gi*ADDR_WIDTH +: ADDR_WIDTH];

        // Read mux. state_r is forced to CLEAR asynchronously, so the ports
        // read zero as soon as reset asserts.
        always_comb begin
            rd_s = '0;
            if (state_r != ST_RUN) begin
                rd_s = '0;
            end else if ((ZERO_REG != 0) && (ra_s == '0)) begin
                rd_s = '0;
            end else if ((BYPASS != 0) && rd_wen && (ra_s == rd_waddr)) begin
                rd_s = rd_wdata;
            end else begin
                rd_s = mem_r[ra_s];
            end
        end

        assign rdata[gi*DATA_WIDTH +: DATA_WIDTH] = rd_s;
    end

endmodule

// File: tb/tb_fwrisc_regfile_p.sv
// -----------------------------------------------------------------------------
// tb_fwrisc_regfile_p
//
// Self-checking bench for fwrisc_regfile_p. It instantiates three copies:
//   u_dut    - default parameters
//   u_nobyp  - BYPASS = 0 (shares the default copy's inputs)
//   u_wide   - 64-bit data, 32 entries, 3 read ports, no zero register
//
// Expected values are pushed to exp_q when stimulus is applied. They are
// popped and compared once the outputs have settled.
// -----------------------------------------------------------------------------
module tb_fwrisc_regfile_p;

    logic        clock = 1'b0;
    logic        reset = 1'b0;

    logic [11:0] raddr = 12'd0;
    logic [63:0] rdata;
    logic [63:0] nb_rdata;
    logic [5:0]  rd_waddr = 6'd0;
    logic [31:0] rd_wdata = 32'd0;
    logic        rd_wen = 1'b0;
    logic        clr_req = 1'b0;
    logic        ready;
    logic        nb_ready;

    logic [14:0]  w_raddr = 15'd0;
    logic [191:0] w_rdata;
    logic [4:0]   w_waddr = 5'd0;
    logic [63:0]  w_wdata = 64'd0;
    logic         w_wen = 1'b0;
    logic         w_clr = 1'b0;
    logic         w_ready;

    int          n_checks = 0;
    int          n_fail = 0;
    logic [63:0] exp_q[$];
    logic [63:0] exp_v;

    always #5 clock = ~clock;

    fwrisc_regfile_p u_dut (
        .clock(clock), .reset(reset), .raddr(raddr), .rdata(rdata),
        .rd_waddr(rd_waddr), .rd_wdata(rd_wdata), .rd_wen(rd_wen),
        .clr_req(clr_req), .ready(ready)
    );

    fwrisc_regfile_p #(.BYPASS(0)) u_nobyp (
        .clock(clock), .reset(reset), .raddr(raddr), .rdata(nb_rdata),
        .rd_waddr(rd_waddr), .rd_wdata(rd_wdata), .rd_wen(rd_wen),
        .clr_req(clr_req), .ready(nb_ready)
    );

    fwrisc_regfile_p #(.DATA_WIDTH(64), .ADDR_WIDTH(5), .N_READ(3),
                       .ZERO_REG(0)) u_wide (
        .clock(clock), .reset(reset), .raddr(w_raddr), .rdata(w_rdata),
        .rd_waddr(w_waddr), .rd_wdata(w_wdata), .rd_wen(w_wen),
        .clr_req(w_clr), .ready(w_ready)
    );

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        raddr = {6'd5, 6'd0};
        repeat (3) @(posedge clock);
        #1;
        exp_q.push_back(64'd0);
        exp_q.push_back(64'd0);
        n_checks++; exp_v = exp_q.pop_front();
        if ({63'd0, ready} !== exp_v) begin
            n_fail++; $display("FAIL reset_ready_in_reset: got %h expected %h", ready, exp_v);
        end
        n_checks++; exp_v = exp_q.pop_front();
        if (rdata !== exp_v) begin
            n_fail++; $display("FAIL reset_rdata_in_reset: got %h expected %h", rdata, exp_v);
        end
        reset = 1'b1;
        for (int i = 0; i <= 64; i++) begin
            exp_q.push_back(64'(i >= 64));
            exp_q.push_back(64'(i >= 32));
            n_checks++; exp_v = exp_q.pop_front();
            if ({63'd0, ready} !== exp_v) begin
                n_fail++; $display("FAIL reset_ready cycle %0d: got %h expected %h", i, ready, exp_v);
            end
            n_checks++; exp_v = exp_q.pop_front();
            if ({63'd0, w_ready} !== exp_v) begin
                n_fail++; $display("FAIL wide_ready cycle %0d: got %h expected %h", i, w_ready, exp_v);
            end
            if (i < 64) step();
        end
        exp_q.push_back(64'd1);
        n_checks++; exp_v = exp_q.pop_front();
        if ({63'd0, nb_ready} !== exp_v) begin
            n_fail++; $display("FAIL nobyp_ready: got %h expected %h", nb_ready, exp_v);
        end
        for (int a = 0; a < 64; a++) begin
            raddr   = {6'(63 - a), 6'(a)};
            w_raddr = {5'(a), 5'(a), 5'(a)};
            exp_q.push_back(64'd0);
            exp_q.push_back(64'd0);
            #2;
            n_checks++; exp_v = exp_q.pop_front();
            if (rdata !== exp_v) begin
                n_fail++; $display("FAIL reset_entries addr %0d: got %h expected %h", a, rdata, exp_v);
            end
            n_checks++; exp_v = exp_q.pop_front();
            if (w_rdata[63:0] !== exp_v) begin
                n_fail++; $display("FAIL wide_entries addr %0d: got %h expected %h", a, w_rdata[63:0], exp_v);
            end
            step();
        end
    endtask

    task automatic test_write_readback();
        rd_wen = 1'b1; rd_waddr = 6'd5; rd_wdata = 32'hDEADBEEF;
        step();
        rd_wen = 1'b0;
        raddr = {6'd5, 6'd5};
        exp_q.push_back({32'hDEADBEEF, 32'hDEADBEEF});
        exp_q.push_back({32'hDEADBEEF, 32'hDEADBEEF});
        #2;
        n_checks++; exp_v = exp_q.pop_front();
        if (rdata !== exp_v) begin
            n_fail++; $display("FAIL readback_r5: got %h expected %h", rdata, exp_v);
        end
        n_checks++; exp_v = exp_q.pop_front();
        if (nb_rdata !== exp_v) begin
            n_fail++; $display("FAIL readback_r5_nobyp: got %h expected %h", nb_rdata, exp_v);
        end
        step();
        rd_wen = 1'b1; rd_waddr = 6'd0; rd_wdata = 32'h11111111;
        raddr = {6'd5, 6'd0};
        exp_q.push_back({32'hDEADBEEF, 32'h0});
        #2;
        n_checks++; exp_v = exp_q.pop_front();
        if (rdata !== exp_v) begin
            n_fail++; $display("FAIL r0_no_bypass: got %h expected %h", rdata, exp_v);
        end
        step();
        rd_wen = 1'b0;
        raddr = {6'd0, 6'd0};
        exp_q.push_back(64'd0);
        #2;
        n_checks++; exp_v = exp_q.pop_front();
        if (rdata !== exp_v) begin
            n_fail++; $display("FAIL r0_write_dropped: got %h expected %h", rdata, exp_v);
        end
        step();
    endtask

    task automatic test_bypass();
        raddr = {6'd8, 6'd7};
        rd_wen = 1'b1; rd_waddr = 6'd7; rd_wdata = 32'h12345678;
        exp_q.push_back({32'h0, 32'h12345678});
        exp_q.push_back(64'd0);
        #2;
        n_checks++; exp_v = exp_q.pop_front();
        if (rdata !== exp_v) begin
            n_fail++; $display("FAIL bypass_same_cycle: got %h expected %h", rdata, exp_v);
        end
        n_checks++; exp_v = exp_q.pop_front();
        if (nb_rdata !== exp_v) begin
            n_fail++; $display("FAIL nobyp_old_value: got %h expected %h", nb_rdata, exp_v);
        end
        step();
        rd_wen = 1'b0;
        exp_q.push_back({32'h0, 32'h12345678});
        exp_q.push_back({32'h0, 32'h12345678});
        #2;
        n_checks++; exp_v = exp_q.pop_front();
        if (rdata !== exp_v) begin
            n_fail++; $display("FAIL bypass_after_edge: got %h expected %h", rdata, exp_v);
        end
        n_checks++; exp_v = exp_q.pop_front();
        if (nb_rdata !== exp_v) begin
            n_fail++; $display("FAIL nobyp_after_edge: got %h expected %h", nb_rdata, exp_v);
        end
        step();
    endtask

    task automatic test_write_during_clear();
        raddr = {6'd7, 6'd5};
        exp_q.push_back({32'h12345678, 32'hDEADBEEF});
        #2;
        n_checks++; exp_v = exp_q.pop_front();
        if (rdata !== exp_v) begin
            n_fail++; $display("FAIL pre_reset_data: got %h expected %h", rdata, exp_v);
        end
        reset = 1'b0;
        exp_q.push_back(64'd0);
        exp_q.push_back(64'd0);
        #1;
        n_checks++; exp_v = exp_q.pop_front();
        if (rdata !== exp_v) begin
            n_fail++; $display("FAIL async_reset_rdata: got %h expected %h", rdata, exp_v);
        end
        n_checks++; exp_v = exp_q.pop_front();
        if ({63'd0, ready} !== exp_v) begin
            n_fail++; $display("FAIL async_reset_ready: got %h expected %h", ready, exp_v);
        end
        step();
        reset = 1'b1;
        step();
        step();
        exp_q.push_back(64'd0);
        #2;
        n_checks++; exp_v = exp_q.pop_front();
        if (rdata !== exp_v) begin
            n_fail++; $display("FAIL clear_reads_zero: got %h expected %h", rdata, exp_v);
        end
        repeat (8) step();
        rd_wen = 1'b1; rd_waddr = 6'd3; rd_wdata = 32'hA5A5A5A5;
        step();
        rd_wen = 1'b0;
        for (int k = 0; k < 200 && !ready; k++) step();
        exp_q.push_back(64'd1);
        n_checks++; exp_v = exp_q.pop_front();
        if ({63'd0, ready} !== exp_v) begin
            n_fail++; $display("FAIL clear_timeout_ready: got %h expected %h", ready, exp_v);
        end
        raddr = {6'd5, 6'd3};
        exp_q.push_back(64'd0);
        #2;
        n_checks++; exp_v = exp_q.pop_front();
        if (rdata !== exp_v) begin
            n_fail++; $display("FAIL write_in_clear_lost: got %h expected %h", rdata, exp_v);
        end
        step();
    endtask

    task automatic test_clr_req();
        for (int a = 1; a < 64; a++) begin
            rd_wen = 1'b1; rd_waddr = 6'(a); rd_wdata = 32'(a);
            step();
        end
        rd_wen = 1'b0;
        raddr = {6'd63, 6'd1};
        exp_q.push_back({32'd63, 32'd1});
        #2;
        n_checks++; exp_v = exp_q.pop_front();
        if (rdata !== exp_v) begin
            n_fail++; $display("FAIL fill_readback: got %h expected %h", rdata, exp_v);
        end
        step();
        clr_req = 1'b1;
        rd_wen = 1'b1; rd_waddr = 6'd9; rd_wdata = 32'h0000BEEF;
        step();
        clr_req = 1'b0;
        rd_wen = 1'b0;
        for (int i = 0; i <= 64; i++) begin
            exp_q.push_back(64'(i >= 64));
            n_checks++; exp_v = exp_q.pop_front();
            if ({63'd0, ready} !== exp_v) begin
                n_fail++; $display("FAIL clr_ready cycle %0d: got %h expected %h", i, ready, exp_v);
            end
            if (i < 64) step();
        end
        for (int a = 0; a < 64; a++) begin
            raddr = {6'(63 - a), 6'(a)};
            exp_q.push_back(64'd0);
            #2;
            n_checks++; exp_v = exp_q.pop_front();
            if (rdata !== exp_v) begin
                n_fail++; $display("FAIL clr_entries addr %0d: got %h expected %h", a, rdata, exp_v);
            end
            step();
        end
        clr_req = 1'b1;
        step();
        clr_req = 1'b0;
        repeat (29) step();
        exp_q.push_back(64'd0);
        n_checks++; exp_v = exp_q.pop_front();
        if ({63'd0, ready} !== exp_v) begin
            n_fail++; $display("FAIL clr_mid_sweep_ready: got %h expected %h", ready, exp_v);
        end
        clr_req = 1'b1;
        step();
        clr_req = 1'b0;
        for (int i = 0; i <= 64; i++) begin
            exp_q.push_back(64'(i >= 64));
            n_checks++; exp_v = exp_q.pop_front();
            if ({63'd0, ready} !== exp_v) begin
                n_fail++; $display("FAIL clr_restart_ready cycle %0d: got %h expected %h", 30 + i, ready, exp_v);
            end
            if (i < 64) step();
        end
    endtask

    task automatic test_wide();
        w_wen = 1'b1; w_waddr = 5'd0; w_wdata = 64'hFFFF_FFFF_0000_0001;
        step();
        w_wen = 1'b0;
        w_raddr = 15'd0;
        exp_q.push_back(64'hFFFF_FFFF_0000_0001);
        exp_q.push_back(64'hFFFF_FFFF_0000_0001);
        exp_q.push_back(64'hFFFF_FFFF_0000_0001);
        #2;
        for (int p = 0; p < 3; p++) begin
            n_checks++; exp_v = exp_q.pop_front();
            if (w_rdata[p*64 +: 64] !== exp_v) begin
                n_fail++; $display("FAIL wide_r0 port %0d: got %h expected %h", p, w_rdata[p*64 +: 64], exp_v);
            end
        end
        step();
        w_wen = 1'b1; w_waddr = 5'd31; w_wdata = 64'h0123_4567_89AB_CDEF;
        w_raddr = {5'd31, 5'd0, 5'd31};
        exp_q.push_back(64'h0123_4567_89AB_CDEF);
        exp_q.push_back(64'hFFFF_FFFF_0000_0001);
        exp_q.push_back(64'h0123_4567_89AB_CDEF);
        #2;
        for (int p = 0; p < 3; p++) begin
            n_checks++; exp_v = exp_q.pop_front();
            if (w_rdata[p*64 +: 64] !== exp_v) begin
                n_fail++; $display("FAIL wide_bypass port %0d: got %h expected %h", p, w_rdata[p*64 +: 64], exp_v);
            end
        end
        step();
        w_wen = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    initial begin
        test_reset();
        test_write_readback();
        test_bypass();
        test_write_during_clear();
        test_clr_req();
        test_wide();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
